blinds_ctrl: RTL and testbench
==============================

BLINDS_CTRL -- requirements
Module: blinds_ctrl

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 8, clock cycles of motor drive per quarter-open step (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, width of the step tick counter.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port target_valid  input  1  one-cycle request to move to target.
REQ-006 SHALL have port target  input  2  requested position: 0 closed, 1 quarter, 2 half, 3 fully open.
REQ-007 SHALL have port btn_up  input  1  one-cycle request to open one step.
REQ-008 SHALL have port btn_down  input  1  one-cycle request to close one step.
REQ-009 SHALL have port stop  input  1  abort any motion.
REQ-010 SHALL have port motor_up  output  1  drive motor in the opening direction.
REQ-011 SHALL have port motor_down  output  1  drive motor in the closing direction.
REQ-012 SHALL have port a  output  1  position select MSB (pos[1]) for the blinds mux.
REQ-013 SHALL have port b  output  1  position select LSB (pos[0]) for the blinds mux.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a request completes or is aborted.

Function
REQ-016 SHALL implement states IDLE, UP, DOWN, BRAKE; registered pos[1:0], goal[1:0], tick counter.
REQ-017 In IDLE, request priority SHALL be stop > target_valid > btn_up > btn_down; btn_up and btn_down asserted together with no higher request SHALL be ignored.
REQ-018 btn_up SHALL set goal = min(pos+1, 3); btn_down SHALL set goal = max(pos-1, 0).
REQ-019 In IDLE, goal > pos SHALL transition to UP next cycle; goal < pos to DOWN; goal == pos SHALL stay IDLE and pulse done next cycle.
REQ-020 In UP/DOWN, the tick counter SHALL increment each cycle from 0; on the cycle it equals STEP_TICKS-1, it SHALL clear and pos SHALL step by +1 (UP) or -1 (DOWN).
REQ-021 When the stepped pos equals goal, the next state SHALL be BRAKE; otherwise remain in UP/DOWN.
REQ-022 BRAKE SHALL last exactly one cycle with both motor outputs low, then go to IDLE with done pulsed on that IDLE entry cycle.
REQ-023 motor_up SHALL equal (state==UP); motor_down SHALL equal (state==DOWN); both high simultaneously is forbidden.
REQ-024 Latency: request at edge N -> motor asserted from cycle N+1 for |goal-pos|*STEP_TICKS cycles, then 1 BRAKE cycle, done at the following cycle.
REQ-025 stop in UP/DOWN SHALL go to BRAKE next cycle, clear tick counter, leave pos unchanged (partial step discarded); stop in BRAKE or IDLE SHALL have no effect beyond a done pulse in IDLE.
REQ-026 target_valid, btn_up, btn_down while busy SHALL be ignored (no queuing).
REQ-027 a,b SHALL equal pos[1], pos[0] at all times and change only on step completion.
REQ-028 pos SHALL never wrap: no step below 0 or above 3.

Reset
REQ-029 rst high on a clock edge SHALL force state IDLE, pos=0 (closed), goal=0, counter=0, motor_up=0, motor_down=0, busy=0, done=0, a=0, b=0.
REQ-030 rst mid-motion SHALL de-energize motors on the very next cycle with no BRAKE state and no done pulse; rst SHALL take priority over all inputs.

Structure
REQ-031 Shared package blinds_pkg SHALL hold the state enum and position constants POS_CLOSED=0, POS_QUARTER=1, POS_HALF=2, POS_FULL=3.
REQ-032 Tick counter SHALL be a sub-module step_timer (enable, clear, wrap pulse at STEP_TICKS-1); FSM and position register in blinds_ctrl.

Verification (STEP_TICKS=4)
REQ-033 Reset, then target_valid target=3 -> motor_up high 12 cycles, pos steps 1,2,3 every 4 cycles, 1 BRAKE cycle, done pulse, a=1 b=1.
REQ-034 From pos=3, btn_down -> motor_down 4 cycles, pos=2 (a=1,b=0), done once.
REQ-035 From pos=0, btn_down -> no motor activity, done pulse next cycle, pos stays 0; same for btn_up at pos=3.
REQ-036 Moving 0->3, stop at tick 2 of second step -> BRAKE next cycle, pos=1, done pulse; a later target_valid during motion ignored.
REQ-037 rst asserted mid-DOWN -> next cycle motors low, pos=0, busy=0, no done; btn_up+btn_down together in IDLE -> ignored.

Source files
------------

// File: rtl/blinds_pkg.sv
// Shared types and constants for the motorised blinds controller.
package blinds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        BRAKE = 2'd3
    } state_t;

    localparam logic [1:0] POS_CLOSED  = 2'd0;
    localparam logic [1:0] POS_QUARTER = 2'd1;
    localparam logic [1:0] POS_HALF    = 2'd2;
    localparam logic [1:0] POS_FULL    = 2'd3;

endpackage

// File: rtl/blinds_ctrl_step_timer.sv
// Motor-drive tick counter: counts while enabled, pulses wrap on the last tick of a step.
module step_timer #(
    parameter int unsigned STEP_TICKS = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    logic [CNT_W-1:0] count;

    assign wrap = enable && !clear && (count == CNT_W'(STEP_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/blinds_ctrl.sv
// Blinds position controller: four-position FSM driving an up/down motor in timed steps.
module blinds_ctrl
    import blinds_pkg::*;
#(
    parameter int unsigned STEP_TICKS = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       target_valid,
    input  logic [1:0] target,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       stop,
    output logic       motor_up,
    output logic       motor_down,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done
);

    state_t     state, state_nx;
    logic [1:0] pos, pos_nx;
    logic [1:0] goal, goal_nx;
    logic [1:0] req_goal;
    logic       req;
    logic       done_q, done_nx;
    logic       moving;
    logic       wrap;

    assign moving = (state == UP) || (state == DOWN);

    // stop clears the counter so an aborted partial step is discarded
    step_timer #(
        .STEP_TICKS (STEP_TICKS),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (moving),
        .clear  (stop),
        .wrap   (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pos    <= POS_CLOSED;
            goal   <= POS_CLOSED;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            pos    <= pos_nx;
            goal   <= goal_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        goal_nx  = goal;
        done_nx  = 1'b0;
        req      = 1'b0;
        req_goal = goal;
        case (state)
            IDLE: begin
                if (stop) begin
                    done_nx = 1'b1;
                end else begin
                    req = 1'b1;
                    if (target_valid) begin
                        req_goal = target;
                    end else if (btn_up && !btn_down) begin
                        req_goal = (pos == POS_FULL) ? pos : pos + 2'd1;
                    end else if (btn_down && !btn_up) begin
                        req_goal = (pos == POS_CLOSED) ? pos : pos - 2'd1;
                    end else begin
                        req = 1'b0;
                    end
                    if (req) begin
                        goal_nx = req_goal;
                        if (req_goal > pos) begin
                            state_nx = UP;
                        end else if (req_goal < pos) begin
                            state_nx = DOWN;
                        end else begin
                            done_nx = 1'b1;
                        end
                    end
                end
            end
            UP: begin
                if (stop) begin
                    state_nx = BRAKE;
                end else if (wrap && pos != POS_FULL) begin
                    pos_nx = pos + 2'd1;
                    if (pos_nx == goal) state_nx = BRAKE;
                end
            end
            DOWN: begin
                if (stop) begin
                    state_nx = BRAKE;
                end else if (wrap && pos != POS_CLOSED) begin
                    pos_nx = pos - 2'd1;
                    if (pos_nx == goal) state_nx = BRAKE;
                end
            end
            BRAKE: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign motor_up   = (state == UP);
    assign motor_down = (state == DOWN);
    assign a          = pos[1];
    assign b          = pos[0];
    assign busy       = (state != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_blinds_ctrl.sv
// Directed scoreboard bench for blinds_ctrl with STEP_TICKS=4.
module tb_blinds_ctrl;

    localparam int unsigned STEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       target_valid = 1'b0;
    logic [1:0] target = 2'd0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       stop = 1'b0;
    logic       motor_up, motor_down, a, b, busy, done;

    // expectation vector: {motor_up, motor_down, a, b, busy, done}
    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    blinds_ctrl #(.STEP_TICKS(STEP), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .target_valid (target_valid),
        .target       (target),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .stop         (stop),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int n, input logic mu, input logic md,
                        input logic [1:0] p, input logic bz, input logic dn);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = tag;
            e.v   = {mu, md, p[1], p[0], bz, dn};
            q.push_back(e);
        end
    endtask

    // expected trace of a full move from p0 to g, ending with two idle cycles
    task automatic plan_move(input string tag, input logic [1:0] p0, input logic [1:0] g);
        int p;
        p = p0;
        while (p != g) begin
            push(tag, STEP, g > p0, g < p0, 2'(p), 1'b1, 1'b0);
            p = (g > p0) ? p + 1 : p - 1;
        end
        push(tag, 1, 1'b0, 1'b0, g, 1'b1, 1'b0);
        push(tag, 1, 1'b0, 1'b0, g, 1'b0, 1'b1);
        push(tag, 1, 1'b0, 1'b0, g, 1'b0, 1'b0);
    endtask

    // advance one cycle, release one-shot inputs, compare against the oldest expectation
    task automatic cyc();
        exp_t       e;
        logic [5:0] obs;
        @(negedge clk);
        target_valid = 1'b0;
        btn_up       = 1'b0;
        btn_down     = 1'b0;
        stop         = 1'b0;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty obs=%0d exp=>0", q.size());
        end else begin
            e   = q.pop_front();
            obs = {motor_up, motor_down, a, b, busy, done};
            vectors++;
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s t=%0t obs=%b exp=%b", e.tag, $time, obs, e.v);
            end
        end
    endtask

    task automatic drain();
        while (q.size() > 0) cyc();
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        push("reset", 2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        drain();
        rst = 1'b0;

        target_valid = 1'b1; target = 2'd3;
        plan_move("open_0_to_3", 2'd0, 2'd3);
        drain();

        btn_down = 1'b1;
        plan_move("btn_down_3_to_2", 2'd3, 2'd2);
        drain();

        target_valid = 1'b1; target = 2'd0;
        plan_move("close_2_to_0", 2'd2, 2'd0);
        drain();

        btn_down = 1'b1;
        push("btn_down_at_closed", 1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        push("btn_down_at_closed", 1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        drain();

        target_valid = 1'b1; target = 2'd3;
        plan_move("reopen_0_to_3", 2'd0, 2'd3);
        drain();

        btn_up = 1'b1;
        push("btn_up_at_full", 1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
        push("btn_up_at_full", 1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        drain();

        target_valid = 1'b1; target = 2'd0;
        plan_move("close_3_to_0", 2'd3, 2'd0);
        drain();

        // stop on tick 2 of the second step; a target during motion is ignored
        target_valid = 1'b1; target = 2'd3;
        push("stop_motion", STEP, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        push("stop_motion", 3, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        push("stop_brake", 1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        push("stop_done", 1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        push("stop_idle", 1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        cyc(); cyc(); cyc();
        target_valid = 1'b1; target = 2'd0;
        cyc(); cyc(); cyc(); cyc();
        stop = 1'b1;
        drain();

        stop = 1'b1;
        push("stop_in_idle", 1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        push("stop_in_idle", 1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        drain();

        // reset mid-DOWN from pos 1: no brake, no done
        btn_down = 1'b1;
        push("down_before_rst", 2, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
        push("rst_mid_down", 2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drain();

        btn_up = 1'b1; btn_down = 1'b1;
        push("both_buttons", 3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        drain();

        btn_up = 1'b1;
        plan_move("btn_up_0_to_1", 2'd0, 2'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
